pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register for the 5-stage MIPS core (ID/EX, EX/MEM, MEM/WB).
//  Carries an opaque payload plus a Tnew hazard countdown between stages.
//  Adds a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer.
//  The skid buffer decouples the upstream ready path from the downstream ready path.
// PARAMETERS
//  DATA_W       128    payload width (Instr|PC|PC8|ALUOut|RD2|... packed by the instantiating stage)
//  TNEW_W       3      Tnew counter width
//  TNEW_MAX     3'd7   Tnew loaded by reset
//  BUBBLE_DATA  '0     payload of a bubble; low 32 bits are instruction 0x00000000 (nop)
//  SKID         1      0 = single register, combinational in_ready; 1 = 2-entry skid, registered in_ready
//  AGE_ON_HOLD  0      1 = Tnew of a held entry keeps decrementing every cycle while stalled
// PORTS
//  clk        in   1        clock, rising edge
//  reset_n    in   1        asynchronous, active-low reset
//  flush      in   1        synchronous kill of all held entries (branch/exception squash)
//  in_valid   in   1        upstream offers in_data/in_tnew
//  in_ready   out  1        stage can accept; transfer when in_valid & in_ready
//  in_data    in   DATA_W   upstream payload
//  in_tnew    in   TNEW_W   Tnew in the producing stage
//  out_valid  out  1        out_data holds a real instruction
//  out_ready  in   1        downstream consumes; transfer when out_valid & out_ready
//  out_data   out  DATA_W   payload; BUBBLE_DATA whenever out_valid=0
//  out_tnew   out  TNEW_W   Tnew in this stage
//  occupancy  out  2        entries held (0..1 if SKID=0, 0..2 if SKID=1)
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=BUBBLE_DATA, out_tnew=TNEW_MAX, occupancy=0.
//    After reset, in_ready=1. A reset mid-transfer drops every entry; no partial state survives.
//  - Capture Tnew: sat_dec(in_tnew) = (in_tnew==0) ? 0 : in_tnew-1. Never wraps below 0.
//  - AGE_ON_HOLD=1: a main entry stalled with out_ready=0 gets out_tnew <= sat_dec(out_tnew) each cycle.
//    AGE_ON_HOLD=0: the held value is frozen.
//  - SKID=0: in_ready = ~out_valid | out_ready (combinational).
//    On accept, main <= {in_data, sat_dec(in_tnew)} and out_valid <= 1.
//    On a drain with no accept, out_valid <= 0, the payload becomes BUBBLE_DATA and out_tnew becomes 0.
//  - SKID=1: FSM with states EMPTY (occ 0), ONE (occ 1, main only), FULL (occ 2, main+skid).
//    in_ready = (state != FULL), driven from a register.
//     EMPTY: accept -> ONE.
//     ONE:   accept & ~drain -> FULL (into skid); accept & drain -> ONE (main replaced);
//            drain & ~accept -> EMPTY.
//     FULL:  drain -> ONE (skid moves to main, same cycle); else hold. No accept is possible.
//    Order is always preserved: skid never bypasses main.
//  - flush=1 at a clock edge: every state goes to EMPTY and all entries become bubbles (out_tnew=0).
//    An input offered in the same cycle is dropped; flush wins over accept and drain.
//    in_ready is 1 in the cycle after a flush.
//  - Latency: input to output is 1 cycle when EMPTY. Throughput is 1 per cycle with out_ready held high.
//  - Invariants: out_valid=0 implies out_data==BUBBLE_DATA. occupancy equals the FSM state encoding.
// STRUCTURE
//  - Shared package cpu_pkg: tnew_t (logic [TNEW_W-1:0]), TNEW_MAX, NOP_INSTR=32'h0,
//    sat_dec() function, and the stage state enum {ST_EMPTY, ST_ONE, ST_FULL}.
//  - Sub-module pipe_stage_entry: one payload+Tnew+valid register with load, age and clear-to-bubble ports.
//    It is instantiated once for main and once for skid (the skid entry only when SKID=1).
//  - Top level: FSM, in_ready register, entry-select muxing.
// TESTING
//  1. Reset: hold reset_n=0 mid-stream -> out_valid=0, out_tnew=7, out_data=0, occupancy=0.
//     After release, in_ready=1.
//  2. Streaming: out_ready=1, feed 4 entries with in_tnew=2,1,0,3 back-to-back ->
//     out_tnew=1,0,0,2 one cycle later, in order, no bubbles.
//  3. Skid fill (SKID=1): out_ready=0, offer A then B -> occupancy 1 then 2, in_ready=0 after B, C stalls.
//     Raise out_ready -> A, B, C emerge in order.
//  4. Flush with stall: in FULL, assert flush together with in_valid=1 ->
//     next cycle occupancy=0, out_valid=0, out_data=0, in_ready=1; the offered input never appears.
//  5. Aging (AGE_ON_HOLD=1): accept in_tnew=3, hold out_ready=0 for 4 cycles -> out_tnew = 2, 1, 0, 0
//     (saturates, no wrap).
//  6. SKID=0 regression: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle.
//     Then out_ready=1 with in_valid=1 -> simultaneous replace, occupancy stays 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions: Tnew type and helpers, bubble instruction and the
// occupancy states used by inter-stage pipeline registers.
package cpu_pkg;

    localparam int TNEW_W = 3;

    typedef logic [TNEW_W-1:0] tnew_t;

    localparam tnew_t       TNEW_MAX  = 3'd7;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_st_e;

    function automatic tnew_t sat_dec(input tnew_t t);
        return (t == '0) ? '0 : t - tnew_t'(1);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stage link carrying a payload plus its Tnew hazard countdown.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 128,
    parameter int TNEW_W = cpu_pkg::TNEW_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [TNEW_W-1:0] tnew;

    modport master (output valid, output data, output tnew, input  ready);
    modport slave  (input  valid, input  data, input  tnew, output ready);
endinterface

// File: rtl/pipe_stage_entry.sv
// One payload + Tnew + valid register with load, hold-aging and clear-to-bubble.
module pipe_stage_entry import cpu_pkg::*; #(
    parameter int                DATA_W      = 128,
    parameter int                TNEW_W      = cpu_pkg::TNEW_W,
    parameter logic [TNEW_W-1:0] TNEW_MAX    = cpu_pkg::TNEW_MAX,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load,
    input  logic              load_dec,
    input  logic [DATA_W-1:0] load_data,
    input  logic [TNEW_W-1:0] load_tnew,
    input  logic              age,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [TNEW_W-1:0] tnew
);

    localparam logic [TNEW_W-1:0] TNEW_ONE = 1;

    function automatic logic [TNEW_W-1:0] tnew_sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_ONE;
    endfunction

    // Clear beats load beats age; the payload always reads as a bubble when invalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= BUBBLE_DATA;
            tnew  <= TNEW_MAX;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= BUBBLE_DATA;
            tnew  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            tnew  <= load_dec ? tnew_sat_dec(load_tnew) : load_tnew;
        end else if (age) begin
            tnew  <= tnew_sat_dec(tnew);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, Tnew
// countdown and an optional 2-entry skid buffer (registered in_ready).
module pipe_stage_reg import cpu_pkg::*; #(
    parameter int                DATA_W      = 128,
    parameter int                TNEW_W      = cpu_pkg::TNEW_W,
    parameter logic [TNEW_W-1:0] TNEW_MAX    = cpu_pkg::TNEW_MAX,
    // Low 32 bits of a bubble decode as NOP_INSTR.
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
    parameter bit                SKID        = 1'b1,
    parameter bit                AGE_ON_HOLD = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    pipe_stage_reg_if.slave    up,
    pipe_stage_reg_if.master   dn,
    output logic [1:0]         occupancy
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [TNEW_W-1:0] main_tnew;
    logic              main_load;
    logic              main_clear;
    logic              main_dec;
    logic              main_age;
    logic [DATA_W-1:0] main_ld_data;
    logic [TNEW_W-1:0] main_ld_tnew;
    logic              accept;
    logic              drain;

    assign accept   = up.valid & up.ready;
    assign drain    = main_valid & dn.ready;
    assign main_age = AGE_ON_HOLD & main_valid & ~dn.ready;

    assign dn.valid = main_valid;
    assign dn.data  = main_data;
    assign dn.tnew  = main_tnew;

    pipe_stage_entry #(
        .DATA_W      (DATA_W),
        .TNEW_W      (TNEW_W),
        .TNEW_MAX    (TNEW_MAX),
        .BUBBLE_DATA (BUBBLE_DATA)
    ) u_main (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (main_clear),
        .load      (main_load),
        .load_dec  (main_dec),
        .load_data (main_ld_data),
        .load_tnew (main_ld_tnew),
        .age       (main_age),
        .valid     (main_valid),
        .data      (main_data),
        .tnew      (main_tnew)
    );

    generate
        if (SKID) begin : g_skid
            stage_st_e         state;
            stage_st_e         state_nxt;
            logic              ready_q;
            logic              skid_load;
            logic              skid_clear;
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;
            logic [TNEW_W-1:0] skid_tnew;

            pipe_stage_entry #(
                .DATA_W      (DATA_W),
                .TNEW_W      (TNEW_W),
                .TNEW_MAX    (TNEW_MAX),
                .BUBBLE_DATA (BUBBLE_DATA)
            ) u_skid (
                .clk       (clk),
                .reset_n   (reset_n),
                .clear     (skid_clear),
                .load      (skid_load),
                .load_dec  (1'b1),
                .load_data (up.data),
                .load_tnew (up.tnew),
                .age       (1'b0),
                .valid     (skid_valid),
                .data      (skid_data),
                .tnew      (skid_tnew)
            );

            // A held skid entry refills main as-is; its Tnew was already stepped on capture.
            assign main_ld_data = skid_valid ? skid_data : up.data;
            assign main_ld_tnew = skid_valid ? skid_tnew : up.tnew;
            assign main_dec     = ~skid_valid;

            always_comb begin
                state_nxt  = state;
                main_load  = 1'b0;
                main_clear = 1'b0;
                skid_load  = 1'b0;
                skid_clear = 1'b0;
                if (flush) begin
                    state_nxt  = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: if (accept) begin
                            main_load = 1'b1;
                            state_nxt = ST_ONE;
                        end
                        ST_ONE: if (accept && drain) begin
                            main_load = 1'b1;
                        end else if (accept) begin
                            skid_load = 1'b1;
                            state_nxt = ST_FULL;
                        end else if (drain) begin
                            main_clear = 1'b1;
                            state_nxt  = ST_EMPTY;
                        end
                        ST_FULL: if (drain) begin
                            main_load  = 1'b1;
                            skid_clear = 1'b1;
                            state_nxt  = ST_ONE;
                        end
                        default: begin
                            main_clear = 1'b1;
                            skid_clear = 1'b1;
                            state_nxt  = ST_EMPTY;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state   <= ST_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state   <= state_nxt;
                    ready_q <= (state_nxt != ST_FULL);
                end
            end

            assign up.ready  = ready_q;
            assign occupancy = state;
        end else begin : g_single
            assign main_ld_data = up.data;
            assign main_ld_tnew = up.tnew;
            assign main_dec     = 1'b1;

            always_comb begin
                main_load  = 1'b0;
                main_clear = 1'b0;
                if (flush)       main_clear = 1'b1;
                else if (accept) main_load  = 1'b1;
                else if (drain)  main_clear = 1'b1;
            end

            assign up.ready  = ~main_valid | dn.ready;
            assign occupancy = {1'b0, main_valid};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three variants (skid, skid+aging, single register)
// driven by shared stimulus and checked against a queue-level reference.
module tb_pipe_stage_reg;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [2:0]    in_tnew = '0;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW)) up_a (), dn_a (), up_b (), dn_b (), up_c (), dn_c ();
    logic [1:0] occ_a, occ_b, occ_c;

    assign up_a.valid = in_valid;  assign up_a.data = in_data;  assign up_a.tnew = in_tnew;
    assign up_b.valid = in_valid;  assign up_b.data = in_data;  assign up_b.tnew = in_tnew;
    assign up_c.valid = in_valid;  assign up_c.data = in_data;  assign up_c.tnew = in_tnew;
    assign dn_a.ready = out_ready;
    assign dn_b.ready = out_ready;
    assign dn_c.ready = out_ready;

    pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .AGE_ON_HOLD(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(flush), .up(up_a), .dn(dn_a), .occupancy(occ_a));
    pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .AGE_ON_HOLD(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(flush), .up(up_b), .dn(dn_b), .occupancy(occ_b));
    pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0), .AGE_ON_HOLD(1'b0)) dut_c (
        .clk(clk), .reset_n(reset_n), .flush(flush), .up(up_c), .dn(dn_c), .occupancy(occ_c));

    logic          o_valid [3];
    logic [DW-1:0] o_data  [3];
    logic [2:0]    o_tnew  [3];
    logic [1:0]    o_occ   [3];
    logic          o_rdy   [3];

    assign o_valid[0] = dn_a.valid; assign o_data[0] = dn_a.data; assign o_tnew[0] = dn_a.tnew;
    assign o_valid[1] = dn_b.valid; assign o_data[1] = dn_b.data; assign o_tnew[1] = dn_b.tnew;
    assign o_valid[2] = dn_c.valid; assign o_data[2] = dn_c.data; assign o_tnew[2] = dn_c.tnew;
    assign o_occ[0] = occ_a;  assign o_occ[1] = occ_b;  assign o_occ[2] = occ_c;
    assign o_rdy[0] = up_a.ready; assign o_rdy[1] = up_b.ready; assign o_rdy[2] = up_c.ready;

    int n_checks = 0;
    int n_err    = 0;

    // Reference: each variant is an in-order list of at most 2 (1 without skid) entries.
    int            mcnt  [3];
    logic [DW-1:0] mdat  [3][2];
    logic [2:0]    mtn   [3][2];
    logic [2:0]    midle [3];
    bit            mrdy  [3];

    function automatic bit has_skid(input int k);
        return k != 2;
    endfunction

    function automatic bit ages(input int k);
        return k == 1;
    endfunction

    function automatic logic [2:0] dec(input logic [2:0] t);
        return (t == 3'd0) ? 3'd0 : t - 3'd1;
    endfunction

    function automatic bit model_ready(input int k);
        if (has_skid(k)) return mcnt[k] < 2;
        return (mcnt[k] == 0) || out_ready;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k]  = 0;
            midle[k] = 3'd7;
        end
    endtask

    task automatic model_step(input int k, input bit rdy);
        bit drn;
        bit acc;
        if (flush) begin
            mcnt[k]  = 0;
            midle[k] = 3'd0;
            return;
        end
        drn = (mcnt[k] > 0) && out_ready;
        acc = in_valid && rdy;
        if (drn) begin
            mdat[k][0] = mdat[k][1];
            mtn[k][0]  = mtn[k][1];
            mcnt[k]--;
            if (mcnt[k] == 0) midle[k] = 3'd0;
        end else if (ages(k) && mcnt[k] > 0) begin
            mtn[k][0] = dec(mtn[k][0]);
        end
        if (acc) begin
            mdat[k][mcnt[k]] = in_data;
            mtn[k][mcnt[k]]  = dec(in_tnew);
            mcnt[k]++;
        end
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s dut%0d out_valid", tag, k), DW'(o_valid[k]), DW'(mcnt[k] != 0));
            chk($sformatf("%s dut%0d out_data", tag, k), o_data[k], (mcnt[k] != 0) ? mdat[k][0] : '0);
            chk($sformatf("%s dut%0d out_tnew", tag, k), DW'(o_tnew[k]),
                DW'((mcnt[k] != 0) ? mtn[k][0] : midle[k]));
            chk($sformatf("%s dut%0d occupancy", tag, k), DW'(o_occ[k]), DW'(mcnt[k]));
            chk($sformatf("%s dut%0d in_ready", tag, k), DW'(o_rdy[k]), DW'(model_ready(k)));
        end
    endtask

    task automatic set_in(input bit v, input logic [DW-1:0] d, input logic [2:0] t,
                          input bit ordy, input bit fl);
        in_valid  = v;
        in_data   = d;
        in_tnew   = t;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic tick(input string tag);
        check_all(tag);
        for (int k = 0; k < 3; k++) mrdy[k] = model_ready(k);
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, mrdy[k]);
        #1;
    endtask

    task automatic do_reset(input bit check);
        reset_n = 1'b0;
        #1;
        if (check) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("reset dut%0d out_valid", k), DW'(o_valid[k]), '0);
                chk($sformatf("reset dut%0d out_tnew", k), DW'(o_tnew[k]), DW'(7));
                chk($sformatf("reset dut%0d out_data", k), o_data[k], '0);
                chk($sformatf("reset dut%0d occupancy", k), DW'(o_occ[k]), '0);
            end
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_reset();
        #1;
        if (check)
            for (int k = 0; k < 3; k++)
                chk($sformatf("post-reset dut%0d in_ready", k), DW'(o_rdy[k]), DW'(1));
    endtask

    typedef struct {
        bit            rst_first;
        int            k;
        bit            v;
        logic [DW-1:0] d;
        logic [2:0]    t;
        bit            ordy;
        bit            exp_v;
        logic [DW-1:0] exp_d;
        logic [2:0]    exp_t;
        logic [1:0]    exp_occ;
        bit            exp_rdy;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Streaming on the skid variant: Tnew 2,1,0,3 emerges as 1,0,0,2 one cycle later.
        tbl.push_back('{1, 0, 1, 64'hA1, 3'd2, 1, 0, 64'h0,  3'd7, 2'd0, 1});
        tbl.push_back('{0, 0, 1, 64'hA2, 3'd1, 1, 1, 64'hA1, 3'd1, 2'd1, 1});
        tbl.push_back('{0, 0, 1, 64'hA3, 3'd0, 1, 1, 64'hA2, 3'd0, 2'd1, 1});
        tbl.push_back('{0, 0, 1, 64'hA4, 3'd3, 1, 1, 64'hA3, 3'd0, 2'd1, 1});
        tbl.push_back('{0, 0, 0, 64'h0,  3'd0, 1, 1, 64'hA4, 3'd2, 2'd1, 1});
        tbl.push_back('{0, 0, 0, 64'h0,  3'd0, 1, 0, 64'h0,  3'd0, 2'd0, 1});
        // Aging variant: held Tnew steps 2,1,0,0 and saturates.
        tbl.push_back('{1, 1, 1, 64'hB1, 3'd3, 0, 0, 64'h0,  3'd7, 2'd0, 1});
        tbl.push_back('{0, 1, 0, 64'h0,  3'd0, 0, 1, 64'hB1, 3'd2, 2'd1, 1});
        tbl.push_back('{0, 1, 0, 64'h0,  3'd0, 0, 1, 64'hB1, 3'd1, 2'd1, 1});
        tbl.push_back('{0, 1, 0, 64'h0,  3'd0, 0, 1, 64'hB1, 3'd0, 2'd1, 1});
        tbl.push_back('{0, 1, 0, 64'h0,  3'd0, 0, 1, 64'hB1, 3'd0, 2'd1, 1});
        tbl.push_back('{0, 1, 0, 64'h0,  3'd0, 1, 1, 64'hB1, 3'd0, 2'd1, 1});
        tbl.push_back('{0, 1, 0, 64'h0,  3'd0, 0, 0, 64'h0,  3'd0, 2'd0, 1});

        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;

        // Reset in the middle of traffic.
        set_in(1, 64'h11, 3'd1, 0, 0); tick("fill1");
        set_in(1, 64'h22, 3'd2, 0, 0); tick("fill2");
        do_reset(1);

        foreach (tbl[i]) begin
            if (tbl[i].rst_first) do_reset(0);
            set_in(tbl[i].v, tbl[i].d, tbl[i].t, tbl[i].ordy, 1'b0);
            chk($sformatf("vec%0d out_valid", i), DW'(o_valid[tbl[i].k]), DW'(tbl[i].exp_v));
            chk($sformatf("vec%0d out_data", i), o_data[tbl[i].k], tbl[i].exp_d);
            chk($sformatf("vec%0d out_tnew", i), DW'(o_tnew[tbl[i].k]), DW'(tbl[i].exp_t));
            chk($sformatf("vec%0d occupancy", i), DW'(o_occ[tbl[i].k]), DW'(tbl[i].exp_occ));
            chk($sformatf("vec%0d in_ready", i), DW'(o_rdy[tbl[i].k]), DW'(tbl[i].exp_rdy));
            tick($sformatf("vec%0d", i));
        end

        // Skid fill: A, B fill the buffer, C stalls, then all drain in order.
        do_reset(0);
        set_in(1, 64'hA, 3'd4, 0, 0); tick("skid0");
        set_in(1, 64'hB, 3'd4, 0, 0);
        chk("skid occ after A", DW'(occ_a), DW'(1));
        tick("skid1");
        set_in(1, 64'hC, 3'd4, 0, 0);
        chk("skid occ after B", DW'(occ_a), DW'(2));
        chk("skid in_ready full", DW'(up_a.ready), DW'(0));
        tick("skid2");
        set_in(1, 64'hC, 3'd4, 1, 0);
        chk("skid first out", dn_a.data, 64'hA);
        tick("skid3");
        chk("skid second out", dn_a.data, 64'hB);
        tick("skid4");
        set_in(0, 64'h0, 3'd0, 1, 0);
        chk("skid third out", dn_a.data, 64'hC);
        tick("skid5");

        // Flush while full, with a simultaneous offer.
        do_reset(0);
        set_in(1, 64'hF1, 3'd2, 0, 0); tick("fl0");
        set_in(1, 64'hF2, 3'd2, 0, 0); tick("fl1");
        set_in(1, 64'hFF, 3'd5, 0, 1);
        chk("flush pre occ", DW'(occ_a), DW'(2));
        tick("fl2");
        set_in(0, 64'h0, 3'd0, 1, 0);
        chk("flush occ", DW'(occ_a), DW'(0));
        chk("flush out_valid", DW'(dn_a.valid), DW'(0));
        chk("flush out_data", dn_a.data, '0);
        chk("flush out_tnew", DW'(dn_a.tnew), DW'(0));
        chk("flush in_ready", DW'(up_a.ready), DW'(1));
        tick("fl3");
        chk("flush dropped input", DW'(dn_a.valid), DW'(0));
        tick("fl4");

        // Single-register variant: combinational in_ready and simultaneous replace.
        do_reset(0);
        set_in(1, 64'h50, 3'd4, 0, 0); tick("s0");
        set_in(0, 64'h0, 3'd0, 0, 0);
        chk("single stalled in_ready", DW'(up_c.ready), DW'(0));
        set_in(1, 64'h51, 3'd2, 0, 0);
        chk("single offer in_ready", DW'(up_c.ready), DW'(0));
        set_in(1, 64'h51, 3'd2, 1, 0);
        chk("single same-cycle in_ready", DW'(up_c.ready), DW'(1));
        tick("s1");
        set_in(0, 64'h0, 3'd0, 0, 0);
        chk("single replace occ", DW'(occ_c), DW'(1));
        chk("single replace data", dn_c.data, 64'h51);
        chk("single replace tnew", DW'(dn_c.tnew), DW'(1));
        tick("s2");

        // Random traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
            tick($sformatf("rnd%0d", i));
        end
        set_in(0, 64'h0, 3'd0, 1, 0);
        tick("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
